// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared width helpers and the redirect channel search for tagged_dispatcher.
package dispatch_pkg;
  localparam int MAXF = 32;
  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } pick_t;
  function automatic int tag_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  // First non-full channel after start, wrapping modulo n; start itself is never chosen.
  function automatic pick_t next_nonfull(input logic [MAXF-1:0] full, input int start, input int n);
    pick_t r;
    int c;
    r = '0;
    for (int k = 1; k < MAXF; k++) begin
      c = (start + k) % n;
      if (k < n && !r.found && !full[c[4:0]]) r = '{found: 1'b1, idx: c[4:0]};
    end
    return r;
  endfunction
endpackage

// File: rtl/tagged_dispatcher_if.sv
// tagged_dispatcher_if: tagged write-side handshake into the dispatcher.
interface tagged_dispatcher_if #(parameter int WIDTH = 8, parameter int TAGWIDTH = 2);
  logic                push;
  logic [TAGWIDTH-1:0] tag_in;
  logic [WIDTH-1:0]    data_in;
  logic                ready;
  logic                acc;
  logic [TAGWIDTH-1:0] acc_tag;
  modport master (output push, tag_in, data_in, input ready, acc, acc_tag);
  modport slave (input push, tag_in, data_in, output ready, acc, acc_tag);
endinterface

// File: rtl/dispatch_fifo.sv
// dispatch_fifo: one first-word-fall-through channel buffer; head reads 0 while empty.
module dispatch_fifo
  import dispatch_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp, rp;
  logic [CW-1:0]    count;
  logic             wr, rd;
  assign wr       = push & !full;
  assign rd       = pop & !empty;
  assign empty    = count == '0;
  assign full     = count == CW'(DEPTH);
  assign data_out = empty ? '0 : mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wp] <= data_in;
        wp      <= wp + PW'(1);
      end
      if (rd) rp <= rp + PW'(1);
      count <= count + CW'(wr) - CW'(rd);
    end
endmodule

// File: rtl/tagged_dispatcher.sv
// tagged_dispatcher: routes one tagged word per cycle into per-channel FIFOs, counts refused pushes.
// Define REDIRECT_EN to divert words aimed at a full channel to the next non-full one.
module tagged_dispatcher
  import dispatch_pkg::*;
#(
  parameter int NUM_FIFOS = 4,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int TAGWIDTH  = $clog2(NUM_FIFOS),
  parameter int CNTWIDTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  tagged_dispatcher_if.slave         wr,
  input  logic [NUM_FIFOS-1:0]       pop,
  output logic [NUM_FIFOS*WIDTH-1:0] flat_data_out,
  output logic [NUM_FIFOS-1:0]       empty,
  output logic [NUM_FIFOS-1:0]       full,
  output logic [CNTWIDTH-1:0]        drop_cnt
);
  logic                tag_ok, hit_free;
  logic [TAGWIDTH-1:0] dest;
  assign tag_ok   = int'(wr.tag_in) < NUM_FIFOS;
  assign hit_free = tag_ok && !full[wr.tag_in];
`ifdef REDIRECT_EN
  pick_t alt;
  assign alt      = next_nonfull(MAXF'(full), int'(wr.tag_in), NUM_FIFOS);
  assign wr.ready = hit_free | (tag_ok & alt.found);
  assign dest     = hit_free ? wr.tag_in : TAGWIDTH'(alt.idx);
`else
  assign wr.ready = hit_free;
  assign dest     = wr.tag_in;
`endif
  assign wr.acc     = wr.push & wr.ready;
  assign wr.acc_tag = wr.acc ? dest : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) drop_cnt <= '0;
    else if (wr.push && !wr.ready && !(&drop_cnt)) drop_cnt <= drop_cnt + CNTWIDTH'(1);
  for (genvar j = 0; j < NUM_FIFOS; j++) begin : g_ch
    dispatch_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (wr.acc && int'(dest) == j),
      .pop      (pop[j]),
      .data_in  (wr.data_in),
      .data_out (flat_data_out[j*WIDTH +: WIDTH]),
      .empty    (empty[j]),
      .full     (full[j])
    );
  end
endmodule

// File: tb/tb_tagged_dispatcher.sv
// tb_tagged_dispatcher: directed vector table plus hand sequences for reset, saturation and redirect.
module tb_tagged_dispatcher;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  pop = '0;
  logic [31:0] flat_data_out;
  logic [3:0]  empty, full;
  logic [7:0]  drop_cnt;
  int          n_chk = 0;
  int          n_fail = 0;
  tagged_dispatcher_if #(.WIDTH(8), .TAGWIDTH(2)) bus ();
  tagged_dispatcher #(.NUM_FIFOS(4), .WIDTH(8), .DEPTH(4), .TAGWIDTH(2), .CNTWIDTH(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr            (bus),
    .pop           (pop),
    .flat_data_out (flat_data_out),
    .empty         (empty),
    .full          (full),
    .drop_cnt      (drop_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        push;
    logic [1:0]  tag;
    logic [7:0]  data;
    logic [3:0]  pop;
    logic [3:0]  hs;
    logic [3:0]  empty;
    logic [3:0]  full;
    logic [31:0] flat;
    logic [7:0]  drop;
  } vec_t;
  vec_t vec [22];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic cyc(input logic p, input logic [1:0] t, input logic [7:0] d, input logic [3:0] pp);
    bus.push = p;
    bus.tag_in = t;
    bus.data_in = d;
    pop = pp;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    pop = '0;
  endtask
  task automatic hard_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.push = 1'b0;
    bus.tag_in = '0;
    bus.data_in = '0;
    // hs = {ready, acc, acc_tag}
    vec[0]  = '{1'b1, 2'd2, 8'hA5, 4'b0000, 4'b1110, 4'b1011, 4'b0000, 32'h00A5_0000, 8'd0};
    vec[1]  = '{1'b0, 2'd2, 8'h00, 4'b0100, 4'b1000, 4'b1111, 4'b0000, 32'h0000_0000, 8'd0};
    vec[2]  = '{1'b1, 2'd0, 8'h01, 4'b0000, 4'b1100, 4'b1110, 4'b0000, 32'h0000_0001, 8'd0};
    vec[3]  = '{1'b1, 2'd0, 8'h02, 4'b0000, 4'b1100, 4'b1110, 4'b0000, 32'h0000_0001, 8'd0};
    vec[4]  = '{1'b1, 2'd0, 8'h03, 4'b0000, 4'b1100, 4'b1110, 4'b0000, 32'h0000_0001, 8'd0};
    vec[5]  = '{1'b1, 2'd0, 8'h04, 4'b0000, 4'b1100, 4'b1110, 4'b0001, 32'h0000_0001, 8'd0};
    vec[6]  = '{1'b1, 2'd0, 8'h05, 4'b0000, 4'b0000, 4'b1110, 4'b0001, 32'h0000_0001, 8'd1};
    vec[7]  = '{1'b0, 2'd0, 8'h00, 4'b0001, 4'b0000, 4'b1110, 4'b0000, 32'h0000_0002, 8'd1};
    vec[8]  = '{1'b0, 2'd0, 8'h00, 4'b0001, 4'b1000, 4'b1110, 4'b0000, 32'h0000_0003, 8'd1};
    vec[9]  = '{1'b0, 2'd0, 8'h00, 4'b0001, 4'b1000, 4'b1110, 4'b0000, 32'h0000_0004, 8'd1};
    vec[10] = '{1'b0, 2'd0, 8'h00, 4'b0001, 4'b1000, 4'b1111, 4'b0000, 32'h0000_0000, 8'd1};
    vec[11] = '{1'b1, 2'd1, 8'h11, 4'b0000, 4'b1101, 4'b1101, 4'b0000, 32'h0000_1100, 8'd1};
    vec[12] = '{1'b1, 2'd1, 8'h22, 4'b0010, 4'b1101, 4'b1101, 4'b0000, 32'h0000_2200, 8'd1};
    vec[13] = '{1'b0, 2'd1, 8'h00, 4'b0010, 4'b1000, 4'b1111, 4'b0000, 32'h0000_0000, 8'd1};
    vec[14] = '{1'b1, 2'd3, 8'h31, 4'b0000, 4'b1111, 4'b0111, 4'b0000, 32'h3100_0000, 8'd1};
    vec[15] = '{1'b1, 2'd3, 8'h32, 4'b0000, 4'b1111, 4'b0111, 4'b0000, 32'h3100_0000, 8'd1};
    vec[16] = '{1'b1, 2'd3, 8'h33, 4'b0000, 4'b1111, 4'b0111, 4'b0000, 32'h3100_0000, 8'd1};
    vec[17] = '{1'b1, 2'd3, 8'h34, 4'b0000, 4'b1111, 4'b0111, 4'b1000, 32'h3100_0000, 8'd1};
    vec[18] = '{1'b1, 2'd3, 8'h35, 4'b1000, 4'b0000, 4'b0111, 4'b0000, 32'h3200_0000, 8'd2};
    vec[19] = '{1'b1, 2'd3, 8'h36, 4'b0000, 4'b1111, 4'b0111, 4'b1000, 32'h3200_0000, 8'd2};
    vec[20] = '{1'b1, 2'd0, 8'h77, 4'b0001, 4'b1100, 4'b0110, 4'b1000, 32'h3200_0077, 8'd2};
    vec[21] = '{1'b0, 2'd0, 8'h00, 4'b1001, 4'b1000, 4'b0111, 4'b0000, 32'h3300_0000, 8'd2};
    #1;
    chk("reset_empty", 32'(empty), 32'hF);
    chk("reset_full", 32'(full), 32'h0);
    chk("reset_flat", flat_data_out, 32'h0);
    chk("reset_drop", 32'(drop_cnt), 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 22; i++) begin
      bus.push = vec[i].push;
      bus.tag_in = vec[i].tag;
      bus.data_in = vec[i].data;
      pop = vec[i].pop;
      #2;
      chk($sformatf("v%0d_handshake", i), 32'({bus.ready, bus.acc, bus.acc_tag}), 32'(vec[i].hs));
      @(posedge clk);
      #1;
      bus.push = 1'b0;
      pop = '0;
      chk($sformatf("v%0d_empty_full", i), 32'({empty, full}), 32'({vec[i].empty, vec[i].full}));
      chk($sformatf("v%0d_flat", i), flat_data_out, vec[i].flat);
      chk($sformatf("v%0d_drop", i), 32'(drop_cnt), 32'(vec[i].drop));
    end
    // three channels partly filled, then async reset between edges
    cyc(1'b1, 2'd1, 8'h41, 4'b0000);
    cyc(1'b1, 2'd2, 8'h42, 4'b0000);
    chk("pre_rst_empty", 32'(empty), 32'h1);
    #2 rst_n = 1'b0;
    bus.push = 1'b1;
    bus.tag_in = 2'd1;
    #1;
    chk("async_empty", 32'(empty), 32'hF);
    chk("async_full", 32'(full), 32'h0);
    chk("async_flat", flat_data_out, 32'h0);
    chk("async_drop", 32'(drop_cnt), 32'h0);
    chk("async_ready", 32'({bus.ready, bus.acc}), 32'b11);
    bus.push = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b1, 2'd1, 8'h5A, 4'b0000);
    chk("post_rst_head", flat_data_out, 32'h0000_5A00);
    chk("post_rst_empty", 32'(empty), 32'hD);
`ifdef REDIRECT_EN
    hard_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 2'(i / 4), 8'(i), 4'b0000);
    bus.push = 1'b1;
    bus.tag_in = 2'd0;
    bus.data_in = 8'hC3;
    #2;
    chk("redir_handshake", 32'({bus.ready, bus.acc, bus.acc_tag}), 32'b1110);
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    chk("redir_head", flat_data_out, 32'h00C3_0000);
    chk("redir_drop", 32'(drop_cnt), 32'h0);
    for (int i = 0; i < 7; i++) cyc(1'b1, 2'(2 + (i + 1) / 4), 8'h10, 4'b0000);
    chk("redir_allfull", 32'(full), 32'hF);
    bus.push = 1'b1;
    bus.tag_in = 2'd0;
    #2;
    chk("redir_ready_off", 32'({bus.ready, bus.acc}), 32'b00);
    bus.push = 1'b0;
`endif
    hard_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'd0, 8'(i), 4'b0000);
    for (int i = 0; i < 5; i++) cyc(1'b1, 2'd0, 8'hEE, 4'b0000);
    chk("sat_five", 32'(drop_cnt), 32'd5);
    for (int i = 0; i < 250; i++) cyc(1'b1, 2'd0, 8'hEE, 4'b0000);
    chk("sat_255", 32'(drop_cnt), 32'd255);
    for (int i = 0; i < 6; i++) cyc(1'b1, 2'd0, 8'hEE, 4'b0000);
    chk("sat_hold", 32'(drop_cnt), 32'd255);
    chk("sat_head", flat_data_out, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tagged_dispatcher.md
# tagged_dispatcher

Single-stream to multi-FIFO distributor: accepts one tagged data word per cycle and writes it into the per-channel FIFO named by its tag. Each channel is drained independently by its own pop. It is the write-side counterpart of the grant-selected many-to-one FIFO merger, and feeds per-channel consumers in the same fabric. It also exports per-channel status and a saturating count of refused pushes.

## Interface
Parameters:
- NUM_FIFOS, 4, number of output channels (≥2)
- WIDTH, 8, data word width
- DEPTH, 4, entries per channel FIFO (≥2, power of two)
- TAGWIDTH, $clog2(NUM_FIFOS), tag width
- CNTWIDTH, 8, drop counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- push  in  1  input word valid
- tag_in  in  TAGWIDTH  requested destination channel
- data_in  in  WIDTH  input word
- ready  out  1  push at this cycle will be accepted (combinational)
- acc  out  1  push & ready
- acc_tag  out  TAGWIDTH  channel actually written when acc=1, else 0
- pop  in  NUM_FIFOS  per-channel pop
- flat_data_out  out  NUM_FIFOS*WIDTH  head word of channel j at bits [(j+1)*WIDTH-1 : j*WIDTH]
- empty  out  NUM_FIFOS  channel empty (registered)
- full  out  NUM_FIFOS  channel full (registered)
- drop_cnt  out  CNTWIDTH  refused pushes, saturating

## Operation
- Each channel is a circular buffer: write pointer, read pointer, occupancy count of width $clog2(DEPTH+1). empty = (count==0). full = (count==DEPTH).
- Heads are first-word fall-through. flat_data_out shows the head entry while the channel is non-empty, and 0 while it is empty.
- Tag valid means tag_in < NUM_FIFOS. An invalid tag forces ready=0 in all configurations.
- Base routing: ready = valid tag & !full[tag_in]. Destination is tag_in.
- ready uses registered full only. A push to a full channel is refused even if the same channel pops that cycle.
- Pop on an empty channel is ignored: no pointer or count change, no error.
- Simultaneous push and pop on the same non-full, non-empty channel: count is unchanged and both pointers advance.
- Simultaneous push and pop on an empty channel: push is accepted and pop is ignored. Result: count=1.
- push & !ready is a drop. drop_cnt increments by 1 and saturates at 2^CNTWIDTH-1.
- Pops on different channels are independent. Any subset of pop bits may be set in the same cycle.

## Timing
- Accepted word is visible on flat_data_out of its channel at the next edge (latency 1). empty falls at that same edge.
- A pop takes effect at the edge: the next entry appears, or the head goes to 0 and empty rises.
- ready, acc and acc_tag are combinational from push, tag_in and registered full.
- Reset, asynchronous, while rst_n=0:
  - all pointers and counts = 0, storage cleared
  - empty = all 1, full = all 0
  - flat_data_out = 0, drop_cnt = 0
  - ready follows tag validity with full=0
- Reset mid-operation discards all queued data immediately. The first push after rst_n rises is accepted normally.

## Configuration
- REDIRECT_EN defined: when the tag is valid but full[tag_in]=1, the word goes to the first non-full channel scanning tag_in+1, tag_in+2, … modulo NUM_FIFOS.
  - ready = 0 only if every channel is full (or the tag is invalid).
  - acc_tag reports the substituted channel.
- REDIRECT_EN undefined: no redirection. acc_tag = tag_in whenever acc=1.

## Structure
- Package dispatch_pkg:
  - tag and count width helpers
  - function next_nonfull(full vector, start tag) returning the found flag and index, used only under REDIRECT_EN
- Sub-module dispatch_fifo: one channel's circular buffer with async active-low reset, push/pop/data_in/data_out/empty/full. Instantiate NUM_FIFOS times in a generate loop.
- Top holds routing, ready/acc logic and drop counter.

## Test plan
- Reset, then push tag=2 data=8'hA5 → next cycle empty[2]=0, channel-2 head=8'hA5, other channels empty. Pop[2] → empty[2]=1, head=0.
- Push DEPTH=4 words 1,2,3,4 to channel 0, then a fifth word → full[0]=1, ready=0, drop_cnt=1. Pops return 1,2,3,4 in order.
- Channel 1 holding 1 entry, push and pop[1] in the same cycle → count stays 1, new word becomes head next cycle.
- Channel 3 full with push tag=3 and pop[3] in the same cycle → push refused, drop_cnt+1, count becomes 3.
- REDIRECT_EN, channels 0 and 1 full, push tag=0 → acc=1, acc_tag=2, word appears at channel 2. All channels full → ready=0.
- Assert rst_n low with 3 channels partially filled → empty all 1, full all 0 and drop_cnt 0 immediately, before any clock edge. 2^CNTWIDTH+5 drops → drop_cnt stays at all ones.
